// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer: register addresses, table depth,
// control-word field positions, FSM state encoding and a control-word helper.
package led_pkg;

    localparam int STEPS = 8;

    localparam logic [5:0] ADDR_CTRL      = 6'h00;
    localparam logic [5:0] ADDR_LEN       = 6'h01;
    // Step table occupies 0x20..0x2F: bits[3:1] select the step, bit0 picks word A/B.
    localparam logic [5:0] ADDR_STEP_BASE = 6'h20;
    localparam logic [5:0] ADDR_STEP_MASK = 6'h30;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_LOOP_BIT = 1;

    localparam int CW_EN_BIT     = 0;
    localparam int CW_BRIGHT_LSB = 1;
    localparam int CW_BRIGHT_MSB = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    function automatic logic [15:0] ctrl_word(input logic [7:0] bright);
        logic [15:0] w;
        w = '0;
        w[CW_EN_BIT] = 1'b1;
        w[CW_BRIGHT_MSB:CW_BRIGHT_LSB] = bright;
        return w;
    endfunction

endpackage

// File: rtl/led_step_table.sv
// Step table: 8 entries of two 16-bit words.
//   word A = {R[15:8], G[7:0]}, word B = {B[15:8], HOLD[7:0]}
// Ports:
//   clock, reset (sync, active-low; clears every entry)
//   wr_en, wr_addr[5:0], wr_data[15:0] : register write port, decodes 0x20..0x2F
//   rd_idx[2:0]                        : asynchronous read index
//   rd_a[15:0], rd_b[15:0]             : words of entry rd_idx
module led_step_table #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [2:0]  rd_idx,
    output logic [15:0] rd_a,
    output logic [15:0] rd_b
);
    import led_pkg::*;

    logic [15:0] mem_a [DEPTH];
    logic [15:0] mem_b [DEPTH];
    logic        hit;
    logic [2:0]  wr_idx;

    assign hit    = wr_en && ((wr_addr & ADDR_STEP_MASK) == ADDR_STEP_BASE);
    assign wr_idx = wr_addr[3:1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else if (hit) begin
            if (wr_addr[0])
                mem_b[wr_idx] <= wr_data;
            else
                mem_a[wr_idx] <= wr_data;
        end
    end

    assign rd_a = mem_a[rd_idx];
    assign rd_b = mem_b[rd_idx];

endmodule

// File: rtl/led_sequencer.sv
// LED colour sequencer: plays steps 0..LEN from the step table, each held for
// (HOLD+1) prescaler ticks, optionally looping; drives three channel words.
// Ports:
//   clock, reset (sync, active-low)
//   wr_en, wr_addr[5:0], wr_data[15:0] : register writes (CTRL, LEN, step table)
//   control_red/grn/blu[15:0]          : {7'b0, brightness, enable}
//   busy     : high while playing
//   step_idx : current step
//   done     : one-cycle pulse when a non-looping sequence ends
//
// state | meaning
// IDLE  | outputs zero, waiting for a CTRL write with run=1
// PLAY  | showing step step_idx; run is implied by being in this state
module led_sequencer #(
    parameter int STEPS    = 8,
    parameter int PRESCALE = 12000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] control_red,
    output logic [15:0] control_grn,
    output logic [15:0] control_blu,
    output logic        busy,
    output logic [2:0]  step_idx,
    output logic        done
);
    import led_pkg::*;

    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    state_t         state_q, state_nxt;
    logic           loop_q, loop_nxt;
    logic [2:0]     len_q, len_nxt;
    logic [2:0]     step_q, step_nxt;
    logic [PW-1:0]  pre_q, pre_nxt;
    logic [7:0]     hold_q, hold_nxt;
    logic [7:0]     hcnt_q, hcnt_nxt;
    logic [15:0]    red_q, red_nxt, grn_q, grn_nxt, blu_q, blu_nxt;
    logic           done_q, done_nxt;

    logic [15:0]    rd_a, rd_b;
    logic [2:0]     rd_idx, next_idx;
    logic           ctrl_wr, len_wr, tick, last_tick, wrap;

    // Read port always points at the step that would be loaded next, so the
    // colour is latched on the same edge the step changes.
    led_step_table #(.DEPTH(STEPS)) u_table (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    assign ctrl_wr   = wr_en && (wr_addr == ADDR_CTRL);
    assign len_wr    = wr_en && (wr_addr == ADDR_LEN);
    assign tick      = (pre_q == PRE_LAST);
    assign last_tick = tick && (hcnt_q == hold_q);
    // LEN is compared live so a shortened LEN ends/wraps at the current step.
    assign wrap      = (step_q >= len_q);
    assign next_idx  = wrap ? 3'd0 : step_q + 3'd1;
    assign rd_idx    = (state_q == PLAY) ? next_idx : 3'd0;

    always_ff @(posedge clock) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        step_nxt  = step_q;
        pre_nxt   = pre_q;
        hold_nxt  = hold_q;
        hcnt_nxt  = hcnt_q;
        red_nxt   = red_q;
        grn_nxt   = grn_q;
        blu_nxt   = blu_q;
        done_nxt  = 1'b0;
        loop_nxt  = ctrl_wr ? wr_data[CTRL_LOOP_BIT] : loop_q;
        len_nxt   = len_wr ? wr_data[2:0] : len_q;

        case (state_q)
            IDLE: begin
                if (ctrl_wr && wr_data[CTRL_RUN_BIT]) begin
                    state_nxt = PLAY;
                    step_nxt  = rd_idx;
                    pre_nxt   = '0;
                    hcnt_nxt  = '0;
                    hold_nxt  = rd_b[7:0];
                    red_nxt   = ctrl_word(rd_a[15:8]);
                    grn_nxt   = ctrl_word(rd_a[7:0]);
                    blu_nxt   = ctrl_word(rd_b[15:8]);
                end
            end
            PLAY: begin
                // An explicit stop beats a coincident step-end tick.
                if ((ctrl_wr && !wr_data[CTRL_RUN_BIT]) || (last_tick && wrap && !loop_q)) begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                    pre_nxt   = '0;
                    hcnt_nxt  = '0;
                    hold_nxt  = '0;
                    red_nxt   = '0;
                    grn_nxt   = '0;
                    blu_nxt   = '0;
                    done_nxt  = !(ctrl_wr && !wr_data[CTRL_RUN_BIT]);
                end else if (last_tick) begin
                    step_nxt  = rd_idx;
                    pre_nxt   = '0;
                    hcnt_nxt  = '0;
                    hold_nxt  = rd_b[7:0];
                    red_nxt   = ctrl_word(rd_a[15:8]);
                    grn_nxt   = ctrl_word(rd_a[7:0]);
                    blu_nxt   = ctrl_word(rd_b[15:8]);
                end else if (tick) begin
                    pre_nxt   = '0;
                    hcnt_nxt  = hcnt_q + 8'd1;
                end else begin
                    pre_nxt   = pre_q + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            loop_q <= 1'b0;
            len_q  <= '0;
            step_q <= '0;
            pre_q  <= '0;
            hold_q <= '0;
            hcnt_q <= '0;
            red_q  <= '0;
            grn_q  <= '0;
            blu_q  <= '0;
            done_q <= 1'b0;
        end else begin
            loop_q <= loop_nxt;
            len_q  <= len_nxt;
            step_q <= step_nxt;
            pre_q  <= pre_nxt;
            hold_q <= hold_nxt;
            hcnt_q <= hcnt_nxt;
            red_q  <= red_nxt;
            grn_q  <= grn_nxt;
            blu_q  <= blu_nxt;
            done_q <= done_nxt;
        end
    end

    assign control_red = red_q;
    assign control_grn = grn_q;
    assign control_blu = blu_q;
    assign busy        = (state_q == PLAY);
    assign step_idx    = step_q;
    assign done        = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with PRESCALE=4: vector table for
// colour formatting, hand sequences for timing corners, and randomized
// programs checked against a timeline model of the step schedule.
module tb_led_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] control_red, control_grn, control_blu;
    logic        busy, done;
    logic [2:0]  step_idx;

    int checks = 0;
    int errors = 0;

    led_sequencer #(.STEPS(8), .PRESCALE(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .control_red (control_red),
        .control_grn (control_grn),
        .control_blu (control_blu),
        .busy        (busy),
        .step_idx    (step_idx),
        .done        (done)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
        logic        busy;
        logic [2:0]  step;
        logic        done;
    } obs_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] er;
        logic [15:0] eg;
        logic [15:0] eb;
    } vec_t;

    vec_t vecs[4];

    logic [15:0] m_a[8];
    logic [15:0] m_b[8];
    int          m_len;
    bit          m_loop;

    function automatic logic [15:0] cw(input logic [7:0] bright);
        return {7'b0, bright, 1'b1};
    endfunction

    // Walk the schedule: step i lasts (HOLD_i+1)*4 cycles; after step LEN
    // either wrap to 0 (loop) or end, with done in the first idle cycle.
    function automatic obs_t model_at(input int k);
        obs_t o;
        int t;
        int idx;
        int dur;
        o = '0;
        t = k;
        idx = 0;
        while (1'b1) begin
            dur = (int'(m_b[idx][7:0]) + 1) * 4;
            if (t < dur) begin
                o.r    = cw(m_a[idx][15:8]);
                o.g    = cw(m_a[idx][7:0]);
                o.b    = cw(m_b[idx][15:8]);
                o.busy = 1'b1;
                o.step = 3'(idx);
                return o;
            end
            t -= dur;
            if (idx >= m_len) begin
                if (m_loop) idx = 0;
                else begin
                    o.done = (t == 0);
                    return o;
                end
            end else begin
                idx++;
            end
        end
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.r    = control_red;
        o.g    = control_grn;
        o.b    = control_blu;
        o.busy = busy;
        o.step = step_idx;
        o.done = done;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; inputs are sampled at the following posedge.
    task automatic wr(input logic [5:0] addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clock);
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    task automatic wr_tbl(input int i, input logic [15:0] a, input logic [15:0] b);
        logic [5:0] ad;
        ad = 6'h20 + 6'(2 * i);
        wr(ad, a);
        wr(ad + 6'd1, b);
        m_a[i] = a;
        m_b[i] = b;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        m_len  = 0;
        m_loop = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic run_model(input string name, input int ncyc);
        obs_t e;
        for (int k = 0; k < ncyc; k++) begin
            e = model_at(k);
            chk(name, 64'(observe()), 64'(e));
            @(negedge clock);
        end
    endtask

    // LEN=2, loop, HOLD=0 in steps 0..2 with random colours.
    task automatic setup_loop3();
        do_reset();
        for (int i = 0; i < 3; i++)
            wr_tbl(i, 16'($urandom), {8'($urandom), 8'h00});
        wr(6'h01, 16'd2);
        m_len  = 2;
        m_loop = 1;
    endtask

    initial begin
        logic [15:0] old_a1;
        logic [5:0]  ja;
        int          total;

        @(negedge clock);
        do_reset();
        chk("reset_words", 64'({control_red, control_grn, control_blu}), 64'(0));
        chk("reset_ctl", 64'({busy, step_idx, done}), 64'(0));

        vecs[0] = '{16'hFF00, 16'h8001, 16'h01FF, 16'h0001, 16'h0101};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001};
        vecs[2] = '{16'h1234, 16'h5602, 16'h0025, 16'h0069, 16'h00AD};
        vecs[3] = '{16'hAA55, 16'h7F00, 16'h0155, 16'h00AB, 16'h00FF};
        for (int v = 0; v < 4; v++) begin
            wr_tbl(0, vecs[v].a, vecs[v].b);
            wr(6'h01, 16'd0);
            wr(6'h00, 16'h0001);
            chk("vec_red", 64'(control_red), 64'(vecs[v].er));
            chk("vec_grn", 64'(control_grn), 64'(vecs[v].eg));
            chk("vec_blu", 64'(control_blu), 64'(vecs[v].eb));
            chk("vec_busy", 64'({busy, step_idx}), 64'(4'b1000));
            wr(6'h00, 16'h0000);
            chk("vec_stop", 64'({control_red, control_grn, control_blu, busy, done}), 64'(0));
        end

        // Single step, HOLD=1: 8 cycles of colour, then idle with done once.
        do_reset();
        wr_tbl(0, 16'hFF00, 16'h8001);
        wr(6'h01, 16'd0);
        wr(6'h00, 16'h0001);
        for (int k = 0; k < 8; k++) begin
            chk("one_words", 64'({control_red, control_grn, control_blu}), {16'h0, 16'h01FF, 16'h0001, 16'h0101});
            chk("one_ctl", 64'({busy, done}), 64'(2'b10));
            tick(1);
        end
        chk("one_end_words", 64'({control_red, control_grn, control_blu, busy}), 64'(0));
        chk("one_done", 64'(done), 64'(1));
        tick(1);
        chk("one_done_clear", 64'(done), 64'(0));

        // Looping 0,1,2,0,1 with 4 cycles each.
        setup_loop3();
        wr(6'h00, 16'h0003);
        run_model("loop3", 20);

        // Stop written in the same cycle as a step-end tick.
        setup_loop3();
        wr(6'h00, 16'h0003);
        tick(3);
        chk("stop_pre", 64'({busy, step_idx}), 64'(4'b1000));
        wr(6'h00, 16'h0000);
        chk("stop_at_tick", 64'(observe()), 64'(0));
        tick(1);
        chk("stop_no_done", 64'(observe()), 64'(0));

        // Rewriting STEP_A1 while step 1 shows takes effect on its next load.
        setup_loop3();
        old_a1 = m_a[1];
        wr(6'h00, 16'h0003);
        tick(5);
        chk("tbl_old_red", 64'(control_red), 64'(cw(old_a1[15:8])));
        wr(6'h22, 16'hC33C);
        chk("tbl_hold_red", 64'(control_red), 64'(cw(old_a1[15:8])));
        chk("tbl_hold_grn", 64'(control_grn), 64'(cw(old_a1[7:0])));
        tick(11);
        chk("tbl_step", 64'(step_idx), 64'(1));
        chk("tbl_new_red", 64'(control_red), 64'(16'h0187));
        chk("tbl_new_grn", 64'(control_grn), 64'(16'h0079));

        // run=1 while playing only changes loop.
        do_reset();
        wr_tbl(0, 16'h0102, 16'h0300);
        wr_tbl(1, 16'h0405, 16'h0600);
        wr(6'h01, 16'd1);
        wr(6'h00, 16'h0001);
        tick(2);
        wr(6'h00, 16'h0003);
        chk("rerun_no_restart", 64'({busy, step_idx}), 64'(4'b1000));
        tick(1);
        chk("rerun_step1", 64'(step_idx), 64'(1));
        tick(4);
        chk("rerun_looped", 64'({busy, step_idx, done}), 64'(5'b10000));
        wr(6'h00, 16'h0000);

        // Reset during step 2 clears outputs and table.
        setup_loop3();
        wr(6'h00, 16'h0003);
        tick(9);
        chk("rst_pre_step", 64'(step_idx), 64'(2));
        reset = 1'b0;
        tick(1);
        chk("rst_mid_play", 64'(observe()), 64'(0));
        reset = 1'b1;
        wr(6'h00, 16'h0001);
        chk("rst_table_clr", 64'({control_red, control_grn, control_blu, busy}),
            {15'h0, 16'h0001, 16'h0001, 16'h0001, 1'b1});
        wr(6'h00, 16'h0000);

        // Randomized programs, with writes to unmapped addresses mixed in.
        for (int trial = 0; trial < 12; trial++) begin
            do_reset();
            for (int i = 0; i < 8; i++)
                wr_tbl(i, 16'($urandom), {8'($urandom), 8'($urandom_range(0, 3))});
            for (int j = 0; j < 3; j++) begin
                ja = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(2, 31)) : 6'($urandom_range(48, 63));
                wr(ja, 16'($urandom));
            end
            m_len  = $urandom_range(0, 7);
            m_loop = (trial % 3 == 0);
            wr(6'h01, {13'($urandom), 3'(m_len)});
            total = 0;
            for (int i = 0; i <= m_len; i++)
                total += (int'(m_b[i][7:0]) + 1) * 4;
            wr(6'h00, {14'b0, m_loop, 1'b1});
            run_model("random", m_loop ? 60 : total + 3);
            wr(6'h00, 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have parameter STEPS, default 8: number of table entries, fixed at 8, with a 3-bit index.
REQ-002 The block SHALL have parameter PRESCALE, default 12000: clock cycles per tick (1 ms at 12 MHz); benches use 4.
REQ-003 The block SHALL have port clock, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port wr_en, input, 1 bit: register write strobe, one cycle.
REQ-006 The block SHALL have port wr_addr, input, 6 bits: register address.
REQ-007 The block SHALL have port wr_data, input, 16 bits: register write data.
REQ-008 The block SHALL have ports control_red, control_grn and control_blu, output, 16 bits each: LED channel control words.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in PLAY.
REQ-010 The block SHALL have port step_idx, output, 3 bits: current step.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a non-looping sequence.

Function
REQ-012 The register map SHALL be: 0x00 CTRL, with bit0 run and bit1 loop; 0x01 LEN, with bits[2:0] = last step index; 0x20+2i STEP_A{i}, holding {R[15:8], G[7:0]}; 0x21+2i STEP_B{i}, holding {B[15:8], HOLD[7:0]}; writes to other addresses SHALL be ignored.
REQ-013 Each control word SHALL be formatted as bit0 = enable, bits[8:1] = brightness, bits[15:9] = 0.
REQ-014 The FSM SHALL have exactly the states IDLE and PLAY.
REQ-015 In IDLE, all control words SHALL be 0x0000, busy SHALL be 0, and step_idx SHALL be 0.
REQ-016 A CTRL write with run=1 in cycle N while in IDLE SHALL cause, at cycle N+1: state PLAY, step_idx=0, prescaler=0, hold counter=0, and control words = {7'b0, colour of step 0, 1'b1}.
REQ-017 The prescaler SHALL count 0..PRESCALE-1 in PLAY, with tick asserted when count = PRESCALE-1, after which the count wraps to 0.
REQ-018 Step i SHALL be displayed for exactly (HOLD_i+1)*PRESCALE cycles; HOLD=0 means one tick and HOLD=255 means 256 ticks.
REQ-019 At a step's last tick, if step_idx >= LEN, the block SHALL go to step 0 when loop=1; otherwise it SHALL go to IDLE, clear run, and pulse done for one cycle.
REQ-020 At a step's last tick with step_idx < LEN, the block SHALL increment step_idx and load the new step colour in the next cycle.
REQ-021 The step colour SHALL be latched from the table at step load; table writes during PLAY SHALL take effect only on the next load of that step.
REQ-022 LEN SHALL be compared live at each step boundary; a LEN reduced below step_idx SHALL end or wrap the sequence at the current step's end.
REQ-023 A CTRL write with run=0 in PLAY SHALL force IDLE in the next cycle without a done pulse; if it coincides with a step-end tick, the stop SHALL win.
REQ-024 A CTRL write with run=1 in PLAY SHALL update loop only and SHALL NOT restart the sequence.
REQ-025 A zero brightness in PLAY SHALL still output enable=1, giving word 0x0001.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On reset low at a rising edge, the block SHALL set: state IDLE, run=0, loop=0, LEN=0, prescaler=0, hold counter=0, step_idx=0, all control words 0x0000, busy=0, done=0.
REQ-028 Reset SHALL clear all table entries to 0.
REQ-029 Reset asserted mid-PLAY SHALL take effect in the same cycle, with no done pulse.

Structure
REQ-030 A shared package led_pkg SHALL hold the register address constants, STEPS, the control-word field positions and the FSM state enum.
REQ-031 The step table SHALL be a sub-module led_step_table: an 8-entry memory of 2x16-bit words with a synchronous write port and an asynchronous read port indexed by the next step.

Verification
REQ-032 With PRESCALE=4, LEN=0, STEP0 = {0xFF,0x00,0x80,HOLD=1}, and a CTRL run=1 write at cycle 10, the bench SHALL see control_red=0x01FF, control_grn=0x0001 and control_blu=0x0101 from cycle 11 to 18, then IDLE with all words 0 at cycle 19 and done high at cycle 19 only.
REQ-033 With LEN=2, loop=1 and HOLD=0 in all steps, the bench SHALL see step_idx sequence 0,1,2,0,1 with each value held for 4 cycles and no done pulse.
REQ-034 A CTRL run=0 write in the same cycle as a step-end tick SHALL produce IDLE at the next cycle, step_idx=0 and no done pulse.
REQ-035 A STEP_A1 write while step 1 is showing SHALL leave the output unchanged until step 1 next loads, after which the new colour SHALL appear.
REQ-036 Reset low mid-PLAY at step 2 SHALL give all outputs 0 at the next cycle, and a subsequent run=1 write SHALL produce words 0x0001, because the table was cleared.
